// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters plus registered sync, data-enable and
// line/frame strobes, all advancing on enabled pixel-clock cycles.
module video_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   output logic [9:0] cntx,
   output logic [9:0] cnty,
   output logic       hsync,
   output logic       vsync,
   output logic       draw_area,
   output logic       line_start,
   output logic       frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Window bounds are 11 bits wide so a sync ending exactly at 1024 still compares correctly.
   localparam logic [9:0]  C_H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]  C_V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [10:0] C_H_ACTIVE = 11'(H_ACTIVE);
   localparam logic [10:0] C_V_ACTIVE = 11'(V_ACTIVE);
   localparam logic [10:0] C_HS_START = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] C_HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] C_VS_START = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] C_VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

   logic [9:0]  r_cntx;
   logic [9:0]  r_cnty;
   logic        r_hsync;
   logic        r_vsync;
   logic        r_drawArea;
   logic        r_lineStart;
   logic        r_frameStart;

   logic [10:0] w_cntxExt;
   logic [10:0] w_cntyExt;
   logic        w_hsActive;
   logic        w_vsActive;
   logic        w_drawNext;
   logic        w_lineHead;

   assign w_cntxExt  = {1'b0, r_cntx};
   assign w_cntyExt  = {1'b0, r_cnty};
   assign w_hsActive = (w_cntxExt >= C_HS_START) && (w_cntxExt < C_HS_END);
   assign w_vsActive = (w_cntyExt >= C_VS_START) && (w_cntyExt < C_VS_END);
   assign w_drawNext = (w_cntxExt < C_H_ACTIVE) && (w_cntyExt < C_V_ACTIVE);
   assign w_lineHead = (r_cntx == 10'd0);

   // Flags are decoded from the current position, so they lag the counters by one enabled cycle;
   // strobes are re-evaluated every clock so they never stretch across disabled cycles.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cntx       <= 10'd0;
         r_cnty       <= 10'd0;
         r_hsync      <= ~HS_POL;
         r_vsync      <= ~VS_POL;
         r_drawArea   <= 1'b0;
         r_lineStart  <= 1'b0;
         r_frameStart <= 1'b0;
      end else begin
         r_lineStart  <= en && w_lineHead;
         r_frameStart <= en && w_lineHead && (r_cnty == 10'd0);
         if (en) begin
            if (r_cntx == C_H_LAST) begin
               r_cntx <= 10'd0;
               if (r_cnty == C_V_LAST) begin
                  r_cnty <= 10'd0;
               end else begin
                  r_cnty <= r_cnty + 10'd1;
               end
            end else begin
               r_cntx <= r_cntx + 10'd1;
            end
            r_drawArea <= w_drawNext;
            r_hsync    <= w_hsActive ? HS_POL : ~HS_POL;
            r_vsync    <= w_vsActive ? VS_POL : ~VS_POL;
         end
      end
   end

   assign cntx        = r_cntx;
   assign cnty        = r_cnty;
   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign draw_area   = r_drawArea;
   assign line_start  = r_lineStart;
   assign frame_start = r_frameStart;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a default 640x480 instance and a tiny-raster instance share
// stimulus and are compared every cycle against a position-index reference model.
module tb_video_timing_gen;

   typedef struct {
      logic       rstN;
      logic       en;
      logic [9:0] cntx;
      logic [9:0] cnty;
      logic       hs;
      logic       vs;
      logic       draw;
      logic       ls;
      logic       fs;
   } vecT;

   typedef struct {
      int p;
      logic [9:0] cntx;
      logic [9:0] cnty;
      logic       hs;
      logic       vs;
      logic       draw;
      logic       ls;
      logic       fs;
   } mdlT;

   typedef struct {
      int ha, hfp, hsw, hbp, va, vfp, vsw, vbp;
      bit hpol, vpol;
   } parT;

   logic clk = 1'b0;
   logic rst_n;
   logic en;

   logic [9:0] dCntx, dCnty, sCntx, sCnty;
   logic dHs, dVs, dDraw, dLs, dFs;
   logic sHs, sVs, sDraw, sLs, sFs;

   int checkCount = 0;
   int passCount  = 0;
   bit modelOn    = 1'b0;
   int strobeRepeats = 0;
   logic prevDLs = 1'b0, prevDFs = 1'b0, prevSLs = 1'b0, prevSFs = 1'b0;

   parT pDef   = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b1, 1'b1};
   parT pSmall = '{8, 2, 3, 3, 4, 1, 1, 1, 1'b0, 1'b1};
   mdlT mDef, mSmall;

   vecT vecs [12];

   video_timing_gen dutDef (
      .clk(clk), .rst_n(rst_n), .en(en),
      .cntx(dCntx), .cnty(dCnty), .hsync(dHs), .vsync(dVs),
      .draw_area(dDraw), .line_start(dLs), .frame_start(dFs)
   );

   video_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b0), .VS_POL(1'b1)
   ) dutSmall (
      .clk(clk), .rst_n(rst_n), .en(en),
      .cntx(sCntx), .cnty(sCnty), .hsync(sHs), .vsync(sVs),
      .draw_area(sDraw), .line_start(sLs), .frame_start(sFs)
   );

   always #5 clk = ~clk;

   // Reference: the raster is a linear enabled-cycle index p; position and flags follow by division.
   function automatic mdlT stepModel(mdlT m, parT q, logic rst, logic e);
      int ht = q.ha + q.hfp + q.hsw + q.hbp;
      int vt = q.va + q.vfp + q.vsw + q.vbp;
      int x, y;
      mdlT n = m;
      if (!rst) begin
         n.p = 0; n.cntx = 10'd0; n.cnty = 10'd0;
         n.hs = ~q.hpol; n.vs = ~q.vpol;
         n.draw = 1'b0; n.ls = 1'b0; n.fs = 1'b0;
      end else if (e) begin
         x = m.p % ht;
         y = m.p / ht;
         n.draw = (x < q.ha) && (y < q.va);
         n.hs = (x >= q.ha + q.hfp && x < q.ha + q.hfp + q.hsw) ? q.hpol : ~q.hpol;
         n.vs = (y >= q.va + q.vfp && y < q.va + q.vfp + q.vsw) ? q.vpol : ~q.vpol;
         n.ls = (x == 0);
         n.fs = (m.p == 0);
         n.p = (m.p + 1) % (ht * vt);
         n.cntx = 10'(n.p % ht);
         n.cnty = 10'(n.p / ht);
      end else begin
         n.ls = 1'b0;
         n.fs = 1'b0;
      end
      return n;
   endfunction

   always @(posedge clk) begin
      mDef   = stepModel(mDef, pDef, rst_n, en);
      mSmall = stepModel(mSmall, pSmall, rst_n, en);
   end

   task automatic checkVal(input string name, input int got, input int req);
      checkCount++;
      if (got == req) passCount++;
      else $display("[TB] FAIL %s: got %0d, required %0d", name, got, req);
   endtask

   task automatic checkOutput(input string name, input mdlT m, input logic [9:0] cx,
                              input logic [9:0] cy, input logic hs, input logic vs,
                              input logic draw, input logic ls, input logic fs);
      checkCount++;
      if (cx === m.cntx && cy === m.cnty && hs === m.hs && vs === m.vs &&
          draw === m.draw && ls === m.ls && fs === m.fs) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s @%0t: got x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b, required x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b",
                  name, $time, cx, cy, hs, vs, draw, ls, fs,
                  m.cntx, m.cnty, m.hs, m.vs, m.draw, m.ls, m.fs);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic e);
      rst_n = r;
      en    = e;
      @(posedge clk);
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (modelOn) begin
         checkOutput("model_default", mDef, dCntx, dCnty, dHs, dVs, dDraw, dLs, dFs);
         checkOutput("model_small", mSmall, sCntx, sCnty, sHs, sVs, sDraw, sLs, sFs);
      end
      if ((prevDLs && dLs) || (prevDFs && dFs) || (prevSLs && sLs) || (prevSFs && sFs))
         strobeRepeats++;
      prevDLs = dLs; prevDFs = dFs; prevSLs = sLs; prevSFs = sFs;
   end

   initial begin
      int dDrawCnt, dHsCnt, dHsFirst;
      int sDrawCnt, sHsLowCnt, sVsCnt, sLsCnt, sFsCnt;
      int waitCycles;
      mdlT rstExp;

      for (int i = 0; i < 5; i++) vecs[i] = '{1'b0, 1'b1, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 1'b1, 10'd1, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      vecs[7]  = '{1'b1, 1'b1, 10'd2, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 10'd2, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 1'b1, 10'd3, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 1'b1, 10'd1, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

      rst_n = 1'b0;
      en    = 1'b1;
      $display("[TB] table vectors");
      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].rstN, vecs[i].en);
         rstExp = '{0, vecs[i].cntx, vecs[i].cnty, vecs[i].hs, vecs[i].vs,
                    vecs[i].draw, vecs[i].ls, vecs[i].fs};
         checkOutput($sformatf("vec%0d", i), rstExp, dCntx, dCnty, dHs, dVs, dDraw, dLs, dFs);
         if (i == 0) begin
            checkVal("small_reset_hsync", int'(sHs), 1);
            modelOn = 1'b1;
         end
      end

      $display("[TB] continuous line and small-frame run");
      applyStimulus(1'b0, 1'b1);
      dDrawCnt = 0; dHsCnt = 0; dHsFirst = -1;
      sDrawCnt = 0; sHsLowCnt = 0; sVsCnt = 0; sLsCnt = 0; sFsCnt = 0;
      for (int k = 1; k <= 1700; k++) begin
         applyStimulus(1'b1, 1'b1);
         if (k <= 800) begin
            if (dDraw === 1'b1) dDrawCnt++;
            if (dHs === 1'b1) begin
               dHsCnt++;
               if (dHsFirst < 0) dHsFirst = k;
            end
            if (k == 640) checkVal("de_last_active", int'(dDraw), 1);
            if (k == 641) checkVal("de_first_blank", int'(dDraw), 0);
            if (k == 799) checkVal("cntx_799", int'(dCntx), 799);
            if (k == 800) begin
               checkVal("hwrap_cntx", int'(dCntx), 0);
               checkVal("hwrap_cnty", int'(dCnty), 1);
            end
         end
         if (k <= 112) begin
            if (sDraw === 1'b1) sDrawCnt++;
            if (sHs === 1'b0) sHsLowCnt++;
            if (sVs === 1'b1) sVsCnt++;
            if (sLs === 1'b1) sLsCnt++;
            if (sFs === 1'b1) sFsCnt++;
            if (k == 111) checkVal("small_last_line", int'(sCnty), 6);
            if (k == 112) begin
               checkVal("small_vwrap_cntx", int'(sCntx), 0);
               checkVal("small_vwrap_cnty", int'(sCnty), 0);
            end
         end
      end
      checkVal("line0_de_count", dDrawCnt, 640);
      checkVal("line0_hs_count", dHsCnt, 96);
      checkVal("line0_hs_first", dHsFirst, 657);
      checkVal("small_de_count", sDrawCnt, 32);
      checkVal("small_hs_low_count", sHsLowCnt, 21);
      checkVal("small_vs_count", sVsCnt, 16);
      checkVal("small_ls_count", sLsCnt, 7);
      checkVal("small_fs_count", sFsCnt, 1);

      $display("[TB] randomized enable gating");
      for (int k = 0; k < 3000; k++) begin
         applyStimulus(($urandom_range(0, 499) != 0) ? 1'b1 : 1'b0,
                       ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
      end

      $display("[TB] mid-line reset");
      waitCycles = 0;
      while (dCntx !== 10'd700 && waitCycles < 2000) begin
         applyStimulus(1'b1, 1'b1);
         waitCycles++;
      end
      checkVal("reach_cntx_700", int'(dCntx), 700);
      applyStimulus(1'b0, 1'b1);
      rstExp = '{0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      checkOutput("midreset_outputs", rstExp, dCntx, dCnty, dHs, dVs, dDraw, dLs, dFs);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0);
      checkVal("idle_fs", int'(dFs), 0);
      checkVal("idle_cntx", int'(dCntx), 0);
      applyStimulus(1'b1, 1'b1);
      checkVal("restart_fs", int'(dFs), 1);
      checkVal("restart_ls", int'(dLs), 1);
      checkVal("restart_cntx", int'(dCntx), 1);
      applyStimulus(1'b1, 1'b1);
      checkVal("restart_fs_drop", int'(dFs), 0);

      modelOn = 1'b0;
      checkVal("strobe_no_repeat", strobeRepeats, 0);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
